// File: rtl/mux_sel_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : mux_sel_sequencer_if
//  Purpose  : Bundles the push-button inputs and the select/step outputs of
//             mux_sel_sequencer so that they travel as one port.
//  Signals  : key_n[1:0] raw active-low buttons (bit 0 = up, bit 1 = down)
//             sel[1:0]   registered mux select
//             step_up    one-cycle pulse per accepted up step
//             step_dn    one-cycle pulse per accepted down step
//             conflict   one-cycle pulse when up and down land together
//  Modports : master - drives key_n, observes the rest (board / bench side)
//             slave  - the sequencer itself
//  Revision : 1.0  initial release
// ============================================================================
interface mux_sel_sequencer_if;
   logic [1:0] key_n;
   logic [1:0] sel;
   logic       step_up;
   logic       step_dn;
   logic       conflict;

   modport master (
      output key_n,
      input  sel,
      input  step_up,
      input  step_dn,
      input  conflict
   );

   modport slave (
      input  key_n,
      output sel,
      output step_up,
      output step_dn,
      output conflict
   );
endinterface : mux_sel_sequencer_if
`default_nettype wire

// File: rtl/mux_sel_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : mux_sel_sequencer
//  Purpose  : Generates the 2-bit select of the 3:1 board data mux from two
//             raw active-low push-buttons. Each button is synchronised,
//             debounced and turned into a one-cycle step; the select register
//             counts 0..SEL_MAX and wraps in both directions.
//  Ports    : clk      system clock, rising edge
//             rst      synchronous active-high reset
//             bus_if   mux_sel_sequencer_if.slave
//                        key_n[0] steps up, key_n[1] steps down
//                        sel, step_up, step_dn, conflict outputs
//  Options  : SEL_SEQ_AUTO_EN - when defined, sel also steps up by itself
//             every AUTO_PERIOD cycles; a manual press restarts that interval.
//  Revision : 1.0  initial release
// ============================================================================
module mux_sel_sequencer #(
   parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
   parameter int          SEL_MAX         = 2,
   parameter logic [31:0] AUTO_PERIOD     = 32'd50000000
) (
   input  wire logic              clk,
   input  wire logic              rst,
   mux_sel_sequencer_if.slave     bus_if
);

   localparam logic [15:0] c_db_last  = DEBOUNCE_CYCLES - 16'd1;
   localparam logic [1:0]  c_sel_max  = 2'(SEL_MAX);

   // Two-flop synchroniser per key, released (1) out of reset.
   logic [1:0] r_sync1;
   logic [1:0] r_sync2;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync1 <= 2'b11;
         r_sync2 <= 2'b11;
      end else begin
         r_sync1 <= bus_if.key_n;
         r_sync2 <= r_sync1;
      end
   end

   // Per-key debounce. w_press[k] is high in the single cycle where the
   // debounced state is about to fall 1->0, i.e. an accepted press.
   logic [1:0] w_press;

   for (genvar k = 0; k < 2; k++) begin : g_key
      logic [15:0] r_cnt;
      logic        r_db;

      always_ff @(posedge clk) begin
         if (rst) begin
            r_cnt <= 16'd0;
            r_db  <= 1'b1;
         end else if (r_sync2[k] == r_db) begin
            r_cnt <= 16'd0;
         end else if (r_cnt == c_db_last) begin
            r_db  <= r_sync2[k];
            r_cnt <= 16'd0;
         end else begin
            r_cnt <= r_cnt + 16'd1;
         end
      end

      assign w_press[k] = r_db & ~r_sync2[k] & (r_cnt == c_db_last);
   end

   logic w_manual;
   logic w_auto;

   assign w_manual = |w_press;

`ifdef SEL_SEQ_AUTO_EN
   localparam logic [31:0] c_auto_last = AUTO_PERIOD - 32'd1;

   logic [31:0] r_tick;

   // A manual press in the same cycle as the tick suppresses the auto step.
   assign w_auto = (r_tick == c_auto_last) & ~w_manual;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_tick <= 32'd0;
      end else if (w_manual || (r_tick == c_auto_last)) begin
         r_tick <= 32'd0;
      end else begin
         r_tick <= r_tick + 32'd1;
      end
   end
`else
   // Keeps the parameter referenced in builds without the auto feature.
   logic w_unused_auto_period;
   assign w_unused_auto_period = ^AUTO_PERIOD;
   assign w_auto               = 1'b0;
`endif

   // Step pulses are registered; sel follows one cycle later from those
   // registered pulses, so simultaneous up+down cancels out.
   logic       r_step_up;
   logic       r_step_dn;
   logic       r_conflict;
   logic [1:0] r_sel;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_step_up  <= 1'b0;
         r_step_dn  <= 1'b0;
         r_conflict <= 1'b0;
         r_sel      <= 2'd0;
      end else begin
         r_step_up  <= w_press[0] | w_auto;
         r_step_dn  <= w_press[1];
         r_conflict <= w_press[0] & w_press[1];
         if (r_step_up && !r_step_dn) begin
            r_sel <= (r_sel >= c_sel_max) ? 2'd0 : r_sel + 2'd1;
         end else if (r_step_dn && !r_step_up) begin
            r_sel <= (r_sel == 2'd0) ? c_sel_max : r_sel - 2'd1;
         end
      end
   end

   assign bus_if.sel      = r_sel;
   assign bus_if.step_up  = r_step_up;
   assign bus_if.step_dn  = r_step_dn;
   assign bus_if.conflict = r_conflict;

endmodule : mux_sel_sequencer
`default_nettype wire

// File: doc/mux_sel_sequencer.md
Name: mux_sel_sequencer

Overview:
- Front-end stage that produces the 2-bit select for the 3:1 data mux on the board.
- Takes the two raw active-low push-buttons. Synchronises and debounces each one, then turns each clean press into a one-cycle step.
- Holds a select register that wraps inside 0..SEL_MAX. This register drives the mux sel input directly, replacing the raw KEY wiring.

Parameters:
- DEBOUNCE_CYCLES, 16'd50000: consecutive stable cycles needed before the debounced key state changes. Legal range 2..65535.
- SEL_MAX, 2: highest select value. The select counts 0..SEL_MAX and then wraps.
- AUTO_PERIOD, 32'd50000000: auto-advance interval in cycles. Used only when SEL_SEQ_AUTO_EN is defined.

Ports:
- clk  input  1  system clock; all state changes on the rising edge
- rst  input  1  synchronous, active-high reset
- key_n  input  2  raw push-buttons, active-low, asynchronous to clk. key_n[0] steps up, key_n[1] steps down.
- sel  output  2  registered mux select, always within 0..SEL_MAX
- step_up  output  1  one-cycle pulse on each accepted up-press
- step_dn  output  1  one-cycle pulse on each accepted down-press
- conflict  output  1  one-cycle pulse when both presses are accepted in the same cycle

Behaviour:
- Reset values (synchronous, rst=1 at an edge):
  - sel=0; step_up, step_dn and conflict=0.
  - Synchronizer flops=1 (released); debounced state=1; debounce counters=0.
  - Reset takes priority over every other event, including in the middle of a bounce or a count.
- Synchronizer: two flops per key; no logic between them.
- Debounce, per key, independent of the other key:
  - If the synchronised value equals the debounced state, the counter clears to 0.
  - Otherwise the counter increments.
  - When the counter reaches DEBOUNCE_CYCLES-1 while the values still differ, the debounced state takes the synchronised value and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES synchronised cycles produces no state change.
- Press detection: a press is a debounced 1->0 transition. step_up or step_dn is registered and high for exactly one cycle. A release (0->1) produces no pulse.
- Latency: with key_n[0] held low and stable from edge t (setup met), step_up is high in cycle t+2+DEBOUNCE_CYCLES, ±1 for synchronizer sampling.
- Select update: sel changes on the edge after a pulse, so it is visible one cycle after step_* is high.
  - Up: if sel==SEL_MAX then sel=0, else sel+1.
  - Down: if sel==0 then sel=SEL_MAX, else sel-1.
  - Up and down accepted in the same cycle: step_up=1, step_dn=1 and conflict=1 for that cycle; sel is unchanged.
- Holding a key: exactly one step per press, no auto-repeat. The next step needs a debounced release followed by a new press.
- Arithmetic: 2-bit unsigned. sel never equals a value above SEL_MAX. With SEL_MAX=2, the value 3 is never produced, so the mux default branch is never exercised.
- No state machine beyond the per-key debounce and the select register; the design is fully synchronous.

Optional Feature:
- Macro: SEL_SEQ_AUTO_EN.
- Defined:
  - A 32-bit tick counter advances sel by one step up (same wrap rule) every AUTO_PERIOD cycles.
  - step_up pulses for auto steps as well.
  - Any accepted manual press (up, down or conflict) reloads the tick counter to 0.
  - If an auto tick and a manual press fall in the same cycle, the manual press wins and no auto step occurs.
  - The counter is 0 at reset.
- Not defined: no tick counter is synthesised, and sel changes only on button presses.

Test Plan (bench uses DEBOUNCE_CYCLES=4, SEL_MAX=2, AUTO_PERIOD=20):
- Reset: assert rst for 3 cycles with key_n=2'b11 -> sel=0, step_up=0, step_dn=0, conflict=0. Then hold for 50 idle cycles -> sel stays 0.
- Up presses: 4 presses of key_n[0], each held 10 cycles with 10 released cycles between -> exactly 4 step_up pulses, sel 0->1->2->0->1.
- Down wrap from sel=0: one press on key_n[1] -> step_dn pulses once, sel=2.
- Bounce: toggle key_n[0] every 2 cycles for 20 cycles, then hold low -> exactly one step_up pulse, occurring 2+4 cycles after the stable low begins (±1), and sel advances by 1.
- Simultaneous presses: key_n driven 2'b11->2'b00 on the same edge -> step_up=1, step_dn=1, conflict=1 in one cycle; sel unchanged. Holding 30 cycles produces no further pulses.
- Mid-debounce reset, plus auto mode: assert rst while key_n[0] has been low for 3 cycles -> no pulse, sel=0. With SEL_SEQ_AUTO_EN defined and no presses -> sel steps 0->1->2->0 at cycles 20, 40 and 60 after reset.
